// File: rtl/fifo_read_arbiter.sv
// rtl/fifo_read_arbiter.sv - round-robin arbiter sharing the prefetch FIFO read port
// Optional feature: define FIFO_ARB_FLUSH_EN to add the `flush` input.
module fifo_read_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               reset,
`ifdef FIFO_ARB_FLUSH_EN
  input  logic               flush,
`endif
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  input  logic [NUM_REQ-1:0] req_rd_en,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] req_fifo_empty,
  output logic               fifo_rd_en,
  input  logic               fifo_empty,
  output logic               busy,
  output logic               protocol_err
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {
    IDLE,
    GRANTED
  } state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   next_ptr;
  logic [IW-1:0]   search_start;
  logic [NUM_REQ-1:0] search_mask;
  logic [IW-1:0]   winner;
  logic            found;
  logic            release_now;
  logic            err_now;
  logic            flush_active;
  int              idx;

`ifdef FIFO_ARB_FLUSH_EN
  assign flush_active = flush;
`else
  assign flush_active = 1'b0;
`endif

  // Pointer after the current owner lets go, wrapping at the last requester.
  assign next_ptr = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  assign release_now = (state == GRANTED) && (done[owner] || !req[owner]);

  // Round-robin search: upward from the pointer (or owner+1 on hand-over), owner excluded.
  always_comb begin
    search_start = (state == GRANTED) ? next_ptr : ptr;
    search_mask  = (state == GRANTED) ? (req & ~grant) : req;
    found        = 1'b0;
    winner       = '0;
    idx          = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(search_start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && search_mask[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  // Any pop attempt by a non-owner while data is present is a protocol violation.
  assign err_now = |(req_rd_en & ~grant) & ~fifo_empty;

  // Grant FSM with registered one-hot grant and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      owner        <= '0;
      ptr          <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (err_now) protocol_err <= 1'b1;
      if (flush_active) begin
        state <= IDLE;
        grant <= '0;
        ptr   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (found) begin
              state <= GRANTED;
              owner <= winner;
              grant <= NUM_REQ'(1) << winner;
            end
          end
          GRANTED: begin
            if (release_now) begin
              ptr <= next_ptr;
              if (found) begin
                owner <= winner;
                grant <= NUM_REQ'(1) << winner;
              end else begin
                state <= IDLE;
                grant <= '0;
              end
            end
          end
          default: begin
            state <= IDLE;
            grant <= '0;
          end
        endcase
      end
    end
  end

  assign busy           = |grant;
  assign req_fifo_empty = {NUM_REQ{fifo_empty}} | ~grant;
  assign fifo_rd_en     = busy & req_rd_en[owner] & ~fifo_empty & ~reset & ~flush_active;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb/tb_fifo_read_arbiter.sv - scoreboard bench for fifo_read_arbiter
module tb_fifo_read_arbiter;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] req_rd_en;
  logic [2:0] grant;
  logic [2:0] req_fifo_empty;
  logic       fifo_rd_en;
  logic       fifo_empty;
  logic       busy;
  logic       protocol_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [2:0] grant;
    logic [2:0] rfe;
    logic       busy;
    logic       rd;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  fifo_read_arbiter #(.NUM_REQ(3)) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef FIFO_ARB_FLUSH_EN
    .flush          (flush),
`endif
    .req            (req),
    .done           (done),
    .req_rd_en      (req_rd_en),
    .grant          (grant),
    .req_fifo_empty (req_fifo_empty),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_empty     (fifo_empty),
    .busy           (busy),
    .protocol_err   (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input string field, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %b, expected %b", name, field, act, exp);
    end
  endtask

  // Monitor: compare the DUT against the oldest expectation each cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "grant", grant, e.grant);
      chk(e.name, "req_fifo_empty", req_fifo_empty, e.rfe);
      chk(e.name, "busy", {2'b00, busy}, {2'b00, e.busy});
      chk(e.name, "fifo_rd_en", {2'b00, fifo_rd_en}, {2'b00, e.rd});
      chk(e.name, "protocol_err", {2'b00, protocol_err}, {2'b00, e.err});
    end
  end

  // One cycle of stimulus plus the hand-computed outputs expected during that cycle.
  task automatic step(input string name, input logic rst, input logic fl,
                      input logic [2:0] r, input logic [2:0] d, input logic [2:0] rd,
                      input logic emp, input logic [2:0] eg, input logic erd, input logic eerr);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst;
    flush      = fl;
    req        = r;
    done       = d;
    req_rd_en  = rd;
    fifo_empty = emp;
    e.name  = name;
    e.grant = eg;
    e.rfe   = emp ? 3'b111 : ~eg;
    e.busy  = |eg;
    e.rd    = erd;
    e.err   = eerr;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req = '0; done = '0; req_rd_en = '0; fifo_empty = 1'b0;

    //    name            rst fl  req     done    rd_en   emp   grant  rd    err
    step("reset",         1, 0, 3'b000, 3'b000, 3'b000, 0, 3'b000, 0, 0);
    step("t1_req",        0, 0, 3'b001, 3'b000, 3'b000, 0, 3'b000, 0, 0);
    step("t1_pop_a",      0, 0, 3'b001, 3'b000, 3'b001, 0, 3'b001, 1, 0);
    step("t1_pop_b",      0, 0, 3'b001, 3'b000, 3'b001, 0, 3'b001, 1, 0);
    step("t1_done",       0, 0, 3'b001, 3'b001, 3'b000, 0, 3'b001, 0, 0);
    step("t1_idle",       0, 0, 3'b000, 3'b000, 3'b000, 0, 3'b000, 0, 0);

    step("t2_reset",      1, 0, 3'b000, 3'b000, 3'b000, 0, 3'b000, 0, 0);
    step("t2_req_all",    0, 0, 3'b111, 3'b000, 3'b000, 0, 3'b000, 0, 0);
    step("t2_g0",         0, 0, 3'b111, 3'b000, 3'b000, 0, 3'b001, 0, 0);
    step("t2_d0",         0, 0, 3'b111, 3'b001, 3'b000, 0, 3'b001, 0, 0);
    step("t2_g1",         0, 0, 3'b111, 3'b000, 3'b000, 0, 3'b010, 0, 0);
    step("t2_d1",         0, 0, 3'b111, 3'b010, 3'b000, 0, 3'b010, 0, 0);
    step("t2_g2",         0, 0, 3'b111, 3'b000, 3'b000, 0, 3'b100, 0, 0);
    step("t2_d2",         0, 0, 3'b111, 3'b100, 3'b000, 0, 3'b100, 0, 0);
    step("t2_g0_again",   0, 0, 3'b111, 3'b000, 3'b000, 0, 3'b001, 0, 0);

    step("t3_empty",      0, 0, 3'b111, 3'b000, 3'b001, 1, 3'b001, 0, 0);
    step("t3_nonempty",   0, 0, 3'b111, 3'b000, 3'b001, 0, 3'b001, 1, 0);

    step("t4_bad_pop",    0, 0, 3'b111, 3'b000, 3'b101, 0, 3'b001, 1, 0);
    step("t4_err_set",    0, 0, 3'b111, 3'b000, 3'b000, 0, 3'b001, 0, 1);
    step("t4_err_sticky", 0, 0, 3'b111, 3'b000, 3'b000, 0, 3'b001, 0, 1);
    step("t4_release0",   0, 0, 3'b111, 3'b001, 3'b000, 0, 3'b001, 0, 1);

    step("t5_abort1",     0, 0, 3'b101, 3'b000, 3'b000, 0, 3'b010, 0, 1);
    step("t5_ptr2_wins",  0, 0, 3'b101, 3'b000, 3'b000, 0, 3'b100, 0, 1);
    step("t5_reset_mid",  1, 0, 3'b101, 3'b000, 3'b100, 0, 3'b100, 0, 1);
    step("t5_after_rst",  0, 0, 3'b101, 3'b000, 3'b000, 0, 3'b000, 0, 0);
    step("t5_ptr0_wins",  0, 0, 3'b101, 3'b000, 3'b000, 0, 3'b001, 0, 0);
    step("t5_pop_done",   0, 0, 3'b101, 3'b001, 3'b001, 0, 3'b001, 1, 0);
    step("t5_new_owner",  0, 0, 3'b100, 3'b000, 3'b100, 0, 3'b100, 1, 0);
    step("t5_drop",       0, 0, 3'b000, 3'b000, 3'b000, 0, 3'b100, 0, 0);
    step("t5_idle",       0, 0, 3'b000, 3'b000, 3'b000, 1, 3'b000, 0, 0);

`ifdef FIFO_ARB_FLUSH_EN
    step("t6_reset",      1, 0, 3'b000, 3'b000, 3'b000, 0, 3'b000, 0, 0);
    step("t6_req0",       0, 0, 3'b001, 3'b000, 3'b000, 0, 3'b000, 0, 0);
    step("t6_flush",      0, 1, 3'b011, 3'b001, 3'b001, 0, 3'b001, 0, 0);
    step("t6_after",      0, 0, 3'b010, 3'b000, 3'b000, 0, 3'b000, 0, 0);
    step("t6_grant1",     0, 0, 3'b010, 3'b000, 3'b000, 0, 3'b010, 0, 0);
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
